// File: rtl/trace_ctrl.sv
// trace_ctrl: MMIO-programmed sequencer for the tile memory-transaction tracer.
// Snoops the CPU data bus for an address trigger, counts traced transactions,
// drives the tracer EN/FLUSH controls and raises a completion interrupt.
module trace_ctrl #(
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        host_req,
  input  logic        host_we,
  input  logic [4:0]  host_addr,
  input  logic [31:0] host_wdata,
  output logic        host_ack,
  output logic        host_resp,
  output logic [31:0] host_rdata,
  input  logic        cpu_req,
  input  logic        cpu_ack,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  output logic [3:0]  trace_ctrl_o,
  input  logic        trace_flush_end_i,
  output logic        irq_o
);

  localparam int unsigned TRACE_EN_BIT    = 0;
  localparam int unsigned TRACE_FLUSH_BIT = 1;

  localparam logic [2:0] REG_CTRL   = 3'd0;
  localparam logic [2:0] REG_STATUS = 3'd1;
  localparam logic [2:0] REG_TADDR  = 3'd2;
  localparam logic [2:0] REG_TMASK  = 3'd3;
  localparam logic [2:0] REG_LIMIT  = 3'd4;
  localparam logic [2:0] REG_COUNT  = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ARMED = 3'd1,
    S_TRACE = 3'd2,
    S_TAIL  = 3'd3,
    S_DONE  = 3'd4,
    S_FLUSH = 3'd5
  } state_t;

  state_t               state, state_n;
  logic [CNT_WIDTH-1:0] count, count_n, count_sat, limit;
  logic [CNT_WIDTH:0]   count_inc;
  logic                 done, done_n;
  logic                 trig_en, irq_en, trig_en_eff, irq_en_eff;
  logic [31:0]          trig_addr, trig_mask;
  logic [2:0]           sel;
  logic                 wr, rd, ctrl_wr, start_p, stop_p, flush_p, w1c_done;
  logic                 acc, trig_hit, limit_hit, busy;
  logic [3:0]           trace_ctrl_n;
  logic                 irq_n;
  logic [31:0]          rdata_c;
  logic                 unused_bits;

  assign host_ack    = 1'b1;
  assign unused_bits = ^{cpu_we, host_addr[1:0]};

  // Host request decode; START/STOP/FLUSH are single-cycle pulses
  assign sel         = host_addr[4:2];
  assign wr          = host_req & host_we;
  assign rd          = host_req & ~host_we;
  assign ctrl_wr     = wr && (sel == REG_CTRL);
  assign start_p     = ctrl_wr & host_wdata[0];
  assign stop_p      = ctrl_wr & host_wdata[1];
  assign flush_p     = ctrl_wr & host_wdata[2];
  assign w1c_done    = wr && (sel == REG_STATUS) && host_wdata[3];
  assign trig_en_eff = ctrl_wr ? host_wdata[3] : trig_en;
  assign irq_en_eff  = ctrl_wr ? host_wdata[4] : irq_en;

  // CPU snoop, trigger compare and saturating count arithmetic
  assign acc       = cpu_req & cpu_ack;
  assign trig_hit  = ((cpu_addr ^ trig_addr) & trig_mask) == 32'd0;
  assign count_inc = {1'b0, count} + (CNT_WIDTH+1)'(1);
  assign count_sat = (&count) ? count : count_inc[CNT_WIDTH-1:0];
  assign limit_hit = (limit != '0) && (count_inc == {1'b0, limit});
  assign busy      = (state != S_IDLE) && (state != S_DONE);

  // Next-state, count, DONE flag and registered-output values
  always_comb begin
    state_n      = state;
    count_n      = count;
    done_n       = done;
    trace_ctrl_n = 4'd0;
    irq_n        = 1'b0;
    if (w1c_done) done_n = 1'b0;
    if (flush_p && (state != S_FLUSH)) begin
      state_n = S_FLUSH;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start_p) begin
            state_n = trig_en_eff ? S_ARMED : S_TRACE;
            count_n = '0;
            done_n  = 1'b0;
          end
        end
        S_ARMED: begin
          if (stop_p)                state_n = S_IDLE;
          else if (acc && trig_hit)  state_n = S_TRACE;
        end
        S_TRACE: begin
          if (acc) count_n = count_sat;
          if (stop_p || (acc && limit_hit)) state_n = S_TAIL;
        end
        S_TAIL: begin
          state_n = S_DONE;
          done_n  = 1'b1;
        end
        S_FLUSH: begin
          if (trace_flush_end_i) begin
            state_n = S_IDLE;
            count_n = '0;
          end
        end
        default: state_n = S_IDLE;
      endcase
    end
    trace_ctrl_n[TRACE_EN_BIT]    = (state_n == S_TRACE) || (state_n == S_TAIL);
    trace_ctrl_n[TRACE_FLUSH_BIT] = (state_n == S_FLUSH);
    irq_n = done_n & irq_en_eff;
  end

  // Register read mux; unmapped offsets read zero
  always_comb begin
    rdata_c = 32'd0;
    case (sel)
      REG_CTRL:   rdata_c = {27'd0, irq_en, trig_en, 3'd0};
      REG_STATUS: rdata_c = 32'({busy, done, state});
      REG_TADDR:  rdata_c = trig_addr;
      REG_TMASK:  rdata_c = trig_mask;
      REG_LIMIT:  rdata_c = 32'(limit);
      REG_COUNT:  rdata_c = 32'(count);
      default:    rdata_c = 32'd0;
    endcase
  end

  // State, configuration registers and registered outputs
  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= S_IDLE;
      count        <= '0;
      done         <= 1'b0;
      limit        <= '0;
      trig_en      <= 1'b0;
      irq_en       <= 1'b0;
      trig_addr    <= 32'd0;
      trig_mask    <= 32'd0;
      trace_ctrl_o <= 4'd0;
      irq_o        <= 1'b0;
      host_resp    <= 1'b0;
      host_rdata   <= 32'd0;
    end else begin
      state        <= state_n;
      count        <= count_n;
      done         <= done_n;
      trace_ctrl_o <= trace_ctrl_n;
      irq_o        <= irq_n;
      host_resp    <= rd;
      host_rdata   <= rd ? rdata_c : 32'd0;
      if (ctrl_wr) begin
        trig_en <= host_wdata[3];
        irq_en  <= host_wdata[4];
      end
      if (wr && (sel == REG_TADDR)) trig_addr <= host_wdata;
      if (wr && (sel == REG_TMASK)) trig_mask <= host_wdata;
      if (wr && (sel == REG_LIMIT)) limit     <= host_wdata[CNT_WIDTH-1:0];
    end
  end

endmodule

// File: tb/tb_trace_ctrl.sv
// tb_trace_ctrl: directed bench for trace_ctrl with a cycle-level reference
// model, a 256-entry tracer flush model, and literal spot checks.
module tb_trace_ctrl;

  localparam int unsigned EN_M  = 1;   // trace_ctrl_o EN bit mask
  localparam int unsigned FL_M  = 2;   // trace_ctrl_o FLUSH bit mask
  localparam int          CMAX  = 65535;
  localparam int          M_IDLE = 0, M_ARMED = 1, M_TRACE = 2, M_TAIL = 3, M_DONE = 4, M_FLUSH = 5;

  logic        clk = 1'b0;
  logic        rst;
  logic        host_req, host_we;
  logic [4:0]  host_addr;
  logic [31:0] host_wdata;
  logic        host_ack, host_resp;
  logic [31:0] host_rdata;
  logic        cpu_req, cpu_ack, cpu_we;
  logic [31:0] cpu_addr;
  logic [3:0]  trace_ctrl_o;
  logic        trace_flush_end_i;
  logic        irq_o;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  trace_ctrl dut (
    .clk(clk), .rst(rst),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_ack(host_ack), .host_resp(host_resp),
    .host_rdata(host_rdata),
    .cpu_req(cpu_req), .cpu_ack(cpu_ack), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .trace_ctrl_o(trace_ctrl_o), .trace_flush_end_i(trace_flush_end_i),
    .irq_o(irq_o)
  );

  // Tracer flush model: 256 entries, pointer advances while FLUSH is high
  logic [7:0] fptr = 8'd0;
  always @(posedge clk) if (trace_ctrl_o[1]) fptr <= fptr + 8'd1;
  assign trace_flush_end_i = trace_ctrl_o[1] && (fptr == 8'd255);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model state
  int          m_mode = M_IDLE, m_cnt = 0, m_limit = 0;
  bit          m_done = 0, m_trig_en = 0, m_irq_en = 0, m_valid = 0;
  logic [31:0] m_taddr = 0, m_tmask = 0;
  logic [31:0] e_tc = 0, e_rdata = 0;
  bit          e_irq = 0, e_resp = 0;

  function automatic logic [31:0] model_read(input int sel);
    bit busy;
    busy = !(m_mode == M_IDLE || m_mode == M_DONE);
    case (sel)
      0: return (m_irq_en ? 32'h10 : 32'h0) | (m_trig_en ? 32'h8 : 32'h0);
      1: return (busy ? 32'h10 : 32'h0) | (m_done ? 32'h8 : 32'h0) | 32'(m_mode);
      2: return m_taddr;
      3: return m_tmask;
      4: return 32'(m_limit);
      5: return 32'(m_cnt);
      default: return 32'h0;
    endcase
  endfunction

  // Advance the model by one clock using the inputs present at this edge
  always @(posedge clk) begin
    int  sel, nm;
    bit  wr, rd, acc, hit, st, sp, fl;
    m_valid = 1;
    if (!rst) begin
      m_mode = M_IDLE; m_cnt = 0; m_limit = 0; m_done = 0;
      m_trig_en = 0; m_irq_en = 0; m_taddr = 0; m_tmask = 0;
      e_tc = 0; e_irq = 0; e_resp = 0; e_rdata = 0;
    end else begin
      sel = int'(host_addr[4:2]);
      rd  = host_req && !host_we;
      wr  = host_req && host_we;
      e_resp  = rd;
      e_rdata = rd ? model_read(sel) : 32'h0;
      st  = wr && sel == 0 && host_wdata[0];
      sp  = wr && sel == 0 && host_wdata[1];
      fl  = wr && sel == 0 && host_wdata[2];
      acc = cpu_req && cpu_ack;
      hit = ((cpu_addr ^ m_taddr) & m_tmask) == 32'h0;
      if (wr && sel == 0) begin m_trig_en = host_wdata[3]; m_irq_en = host_wdata[4]; end
      if (wr && sel == 1 && host_wdata[3]) m_done = 0;
      nm = m_mode;
      if (fl && m_mode != M_FLUSH) nm = M_FLUSH;
      else if (m_mode == M_IDLE || m_mode == M_DONE) begin
        if (st) begin nm = m_trig_en ? M_ARMED : M_TRACE; m_cnt = 0; m_done = 0; end
      end else if (m_mode == M_ARMED) begin
        if (sp) nm = M_IDLE;
        else if (acc && hit) nm = M_TRACE;
      end else if (m_mode == M_TRACE) begin
        if (sp || (acc && m_limit != 0 && m_cnt + 1 == m_limit)) nm = M_TAIL;
        if (acc) m_cnt = (m_cnt < CMAX) ? m_cnt + 1 : CMAX;
      end else if (m_mode == M_TAIL) begin
        nm = M_DONE; m_done = 1;
      end else if (m_mode == M_FLUSH && trace_flush_end_i) begin
        nm = M_IDLE; m_cnt = 0;
      end
      m_mode = nm;
      if (wr && sel == 2) m_taddr = host_wdata;
      if (wr && sel == 3) m_tmask = host_wdata;
      if (wr && sel == 4) m_limit = int'(host_wdata[15:0]);
      e_tc  = (m_mode == M_TRACE || m_mode == M_TAIL) ? 32'(EN_M) :
              (m_mode == M_FLUSH) ? 32'(FL_M) : 32'h0;
      e_irq = m_done && m_irq_en;
    end
  end

  // Per-cycle comparison against the model, plus EN/FLUSH cycle tallies
  int en_cycles = 0, fl_cycles = 0;
  always @(negedge clk) begin
    if (m_valid) begin
      check("trace_ctrl", 32'(trace_ctrl_o), e_tc);
      check("irq", 32'(irq_o), 32'(e_irq));
      check("resp", 32'(host_resp), 32'(e_resp));
      check("ack", 32'(host_ack), 32'h1);
      if (e_resp) check("rdata", host_rdata, e_rdata);
      if (trace_ctrl_o[0]) en_cycles++;
      if (trace_ctrl_o[1]) fl_cycles++;
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic host_write(input logic [4:0] a, input logic [31:0] d);
    host_req = 1; host_we = 1; host_addr = a; host_wdata = d;
    tick();
    host_req = 0; host_we = 0;
  endtask

  task automatic host_read(input logic [4:0] a, output logic [31:0] d);
    host_req = 1; host_we = 0; host_addr = a;
    tick();
    host_req = 0;
    d = host_rdata;
  endtask

  task automatic cpu_burst(input int n, input logic [31:0] a);
    cpu_req = 1; cpu_ack = 1; cpu_addr = a;
    for (int i = 0; i < n; i++) tick();
    cpu_req = 0; cpu_ack = 0;
  endtask

  task automatic wait_flush_low();
    int n = 0;
    while (trace_ctrl_o[1] && n < 2000) begin tick(); n++; end
    check("flush_timeout", 32'(n < 2000), 32'h1);
  endtask

  logic [31:0] rv;
  int          snap;

  initial begin
    rst = 0; host_req = 0; host_we = 0; host_addr = 0; host_wdata = 0;
    cpu_req = 0; cpu_ack = 0; cpu_we = 0; cpu_addr = 0;

    // Reset
    tick(); tick();
    check("rst_tc", 32'(trace_ctrl_o), 32'h0);
    check("rst_irq", 32'(irq_o), 32'h0);
    rst = 1;
    host_read(5'h04, rv); check("rst_status", rv, 32'h0);

    // Register file basics
    host_write(5'h08, 32'hDEADBEEF);
    host_read(5'h08, rv); check("taddr_rb", rv, 32'hDEADBEEF);
    host_write(5'h18, 32'h1234);
    host_read(5'h18, rv); check("off6_rd", rv, 32'h0);
    host_write(5'h00, 32'h18);
    host_read(5'h00, rv); check("ctrl_rb", rv, 32'h18);
    host_write(5'h00, 32'h0);
    host_write(5'h0C, 32'h0);

    // LIMIT=3, untriggered capture of 3 accesses
    host_write(5'h10, 32'd3);
    snap = en_cycles;
    host_write(5'h00, 32'h1);
    cpu_burst(3, 32'h40);
    tick(); tick(); tick();
    check("en_cycles", 32'(en_cycles - snap), 32'd4);
    host_read(5'h14, rv); check("count3", rv, 32'd3);
    host_read(5'h04, rv); check("status_done", rv, 32'h0C);

    // Address trigger
    host_write(5'h08, 32'h100);
    host_write(5'h0C, 32'hFFFFFFF0);
    host_write(5'h00, 32'h9);
    cpu_burst(1, 32'h200);
    check("armed_en", 32'(trace_ctrl_o), 32'h0);
    cpu_burst(1, 32'h104);
    check("trig_en", 32'(trace_ctrl_o), 32'(EN_M));
    host_read(5'h14, rv); check("count_at_match", rv, 32'd0);
    host_write(5'h00, 32'h2);
    tick(); tick();
    host_read(5'h04, rv); check("stop_done", rv, 32'h0C);

    // Interrupt timing and W1C
    host_write(5'h10, 32'd1);
    host_write(5'h00, 32'h11);
    cpu_burst(1, 32'h0);
    check("irq_early", 32'(irq_o), 32'h0);
    tick();
    check("irq_set", 32'(irq_o), 32'h1);
    host_write(5'h04, 32'h8);
    check("irq_clr", 32'(irq_o), 32'h0);
    host_read(5'h04, rv); check("status_w1c", rv, 32'h4);

    // STOP coincident with the limit-reaching access
    host_write(5'h10, 32'd2);
    host_write(5'h00, 32'h1);
    cpu_burst(1, 32'h0);
    host_req = 1; host_we = 1; host_addr = 5'h00; host_wdata = 32'h2;
    cpu_req = 1; cpu_ack = 1;
    tick();
    host_req = 0; host_we = 0; cpu_req = 0; cpu_ack = 0;
    tick(); tick();
    host_read(5'h14, rv); check("count_stop_lim", rv, 32'd2);
    host_read(5'h04, rv); check("status_stop_lim", rv, 32'h0C);

    // Buffer flush of a 256-entry tracer
    host_write(5'h04, 32'h8);
    snap = fl_cycles;
    host_write(5'h00, 32'h4);
    wait_flush_low();
    check("flush_cycles", 32'(fl_cycles - snap), 32'd256);
    host_read(5'h04, rv); check("flush_status", rv, 32'h0);
    host_read(5'h14, rv); check("flush_count", rv, 32'h0);

    // FLUSH with simultaneous START while tracing
    host_write(5'h10, 32'd0);
    host_write(5'h00, 32'h1);
    cpu_burst(2, 32'h80);
    check("tr_en", 32'(trace_ctrl_o), 32'(EN_M));
    snap = fl_cycles;
    host_write(5'h00, 32'h5);
    check("tr_flush", 32'(trace_ctrl_o), 32'(FL_M));
    wait_flush_low();
    check("flush2_cycles", 32'(fl_cycles - snap), 32'd256);
    host_read(5'h14, rv); check("flush2_count", rv, 32'h0);
    host_read(5'h04, rv); check("flush2_status", rv, 32'h0);

    // Reset during TRACE
    host_write(5'h00, 32'h1);
    cpu_burst(2, 32'h80);
    rst = 0;
    tick();
    check("midrst_tc", 32'(trace_ctrl_o), 32'h0);
    check("midrst_irq", 32'(irq_o), 32'h0);
    tick();
    rst = 1;
    host_read(5'h04, rv); check("midrst_status", rv, 32'h0);
    host_read(5'h14, rv); check("midrst_count", rv, 32'h0);
    host_read(5'h08, rv); check("midrst_taddr", rv, 32'h0);

    tick(); tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
